// File: rtl/elevator_scan_controller.sv
// N-floor elevator controller: latches hall/cabin requests, serves them in SCAN order,
// times the door per stop and runs hysteretic heater/cooler control from a signed temperature.
`timescale 1ns/1ps
module elevator_scan_controller #(
    parameter int FLOORS      = 8,
    parameter int POS_W       = 3,
    parameter int DOOR_CYCLES = 16,
    parameter int TEMP_W      = 32,
    parameter int T_LOW       = 18,
    parameter int T_HIGH      = 26,
    parameter int HYST        = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     off_btn,
    input  logic [POS_W-1:0]         position,
    input  logic                     at_floor,
    input  logic [FLOORS-1:0]        floor_press_event,
    input  logic [FLOORS-1:0]        cabin_press_event,
    input  logic signed [TEMP_W-1:0] temp,
    output logic                     door,
    output logic                     cooler,
    output logic                     heater,
    output logic                     motor_up,
    output logic                     motor_down,
    output logic [FLOORS-1:0]        pending,
    output logic                     dir_up
);
    localparam int CNT_W = $clog2(DOOR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [POS_W-1:0] TOP_FLOOR = POS_W'(FLOORS - 1);
    localparam logic signed [TEMP_W-1:0] HEAT_ON  = TEMP_W'(T_LOW);
    localparam logic signed [TEMP_W-1:0] HEAT_OFF = TEMP_W'(T_LOW + HYST);
    localparam logic signed [TEMP_W-1:0] COOL_ON  = TEMP_W'(T_HIGH);
    localparam logic signed [TEMP_W-1:0] COOL_OFF = TEMP_W'(T_HIGH - HYST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR_OPEN,
        S_OFF
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              dir_next;
    logic [CNT_W-1:0]  door_cnt;
    logic [FLOORS-1:0] pending_next;
    logic [FLOORS-1:0] pos_onehot;
    logic [FLOORS-1:0] presses;
    logic              in_range;
    logic              valid_floor;
    logic              above;
    logic              below;
    logic              here;
    logic              door_hit;
    logic              door_done;

    // A power-of-two floor count makes every position encoding a real floor.
    generate
        if (FLOORS == (1 << POS_W)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = ({1'b0, position} < (POS_W+1)'(FLOORS));
        end
    endgenerate

    assign valid_floor = at_floor && in_range;
    assign presses     = floor_press_event | cabin_press_event;

    always_comb begin
        pos_onehot = '0;
        above      = 1'b0;
        below      = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (POS_W'(i) == position) pos_onehot[i] = 1'b1;
            if (POS_W'(i) > position)  above = above | pending[i];
            if (POS_W'(i) < position)  below = below | pending[i];
        end
    end

    assign here      = |(pending & pos_onehot);
    // A press at the open door's floor extends the stop instead of becoming a request.
    assign door_hit  = (state == S_DOOR_OPEN) && |(presses & pos_onehot);
    assign door_done = (door_cnt == '0) && !door_hit;

    always_comb begin
        state_next = state;
        dir_next   = dir_up;
        unique case (state)
            S_IDLE: begin
                if (off_btn) begin
                    state_next = S_OFF;
                end else if (valid_floor && here) begin
                    state_next = S_DOOR_OPEN;
                end else if (above || below) begin
                    dir_next   = (above && below) ? dir_up : above;
                    state_next = dir_next ? S_MOVE_UP : S_MOVE_DOWN;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (valid_floor && here) begin
                    state_next = S_DOOR_OPEN;
                end else if (valid_floor && (off_btn ||
                             (state == S_MOVE_UP && position == TOP_FLOOR) ||
                             (state == S_MOVE_DOWN && position == '0))) begin
                    state_next = S_IDLE;
                end
            end
            S_DOOR_OPEN: begin
                if (door_done) begin
                    if (off_btn) begin
                        state_next = S_OFF;
                    end else if (dir_up ? above : below) begin
                        state_next = dir_up ? S_MOVE_UP : S_MOVE_DOWN;
                    end else if (dir_up ? below : above) begin
                        dir_next   = !dir_up;
                        state_next = dir_up ? S_MOVE_DOWN : S_MOVE_UP;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_OFF: begin
                if (!off_btn) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Clearing the served floor wins over a simultaneous press for it.
    always_comb begin
        pending_next = pending | presses;
        if (state == S_OFF || state_next == S_OFF) begin
            pending_next = '0;
        end else if (state == S_DOOR_OPEN || state_next == S_DOOR_OPEN) begin
            pending_next = pending_next & ~pos_onehot;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_IDLE;
            dir_up   <= 1'b1;
            door_cnt <= '0;
            pending  <= '0;
            heater   <= 1'b0;
            cooler   <= 1'b0;
        end else begin
            state   <= state_next;
            dir_up  <= dir_next;
            pending <= pending_next;
            if (state_next == S_DOOR_OPEN && (state != S_DOOR_OPEN || door_hit)) begin
                door_cnt <= CNT_LOAD;
            end else if (state == S_DOOR_OPEN && door_cnt != '0) begin
                door_cnt <= door_cnt - CNT_W'(1);
            end
            // Disjoint hysteresis bands keep heater and cooler from overlapping.
            if (state_next == S_OFF) begin
                heater <= 1'b0;
                cooler <= 1'b0;
            end else begin
                heater <= heater ? (temp < HEAT_OFF) : (temp < HEAT_ON);
                cooler <= cooler ? (temp > COOL_OFF) : (temp > COOL_ON);
            end
        end
    end

    assign motor_up   = (state == S_MOVE_UP);
    assign motor_down = (state == S_MOVE_DOWN);
    assign door       = (state == S_DOOR_OPEN);

endmodule

// File: doc/elevator_scan_controller.md
Name: elevator_scan_controller

Overview:
Parametrised N-floor elevator controller: latches hall and cabin requests per floor, serves them in SCAN (elevator-algorithm) order and times the door. It also runs hysteretic heater/cooler control from a signed cabin temperature. Successor to the single-function elevator controller; top-level control block between the floor sensors/buttons and the motor, door and HVAC drivers.

Parameters:
FLOORS, 8, number of floors served (2..64)
POS_W, 3, width of position; must equal $clog2(FLOORS)
DOOR_CYCLES, 16, clock cycles the door stays open per stop (>=2)
TEMP_W, 32, width of signed temp input
T_LOW, 18, heater turn-on threshold (signed)
T_HIGH, 26, cooler turn-on threshold (signed); T_HIGH > T_LOW + 2*HYST
HYST, 1, hysteresis band (signed, >=0)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
off_btn  in  1  level; request controller shutdown
position  in  POS_W  floor index from shaft sensor
at_floor  in  1  cabin aligned with floor given by position
floor_press_event  in  FLOORS  hall-button pulses, one bit per floor
cabin_press_event  in  FLOORS  cabin-button pulses, one bit per floor
temp  in  TEMP_W  signed cabin temperature
door  out  1  1 = door open
cooler  out  1  cooler enable
heater  out  1  heater enable
motor_up  out  1  drive cabin upward
motor_down  out  1  drive cabin downward
pending  out  FLOORS  latched outstanding requests
dir_up  out  1  current/last travel direction (1 = up)

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset==0 at a rising edge): state=IDLE, pending=0, dir_up=1, door counter=0, and door, cooler, heater, motor_up and motor_down all 0.
- Request latch: on each edge, pending |= floor_press_event | cabin_press_event, except in OFF. A request appears on pending 1 cycle after the press.
- A press for the floor where the door is currently open is not latched. Instead it reloads the door counter.
- valid_floor = at_floor && (position < FLOORS). When valid_floor==0 the position is ignored for stopping.
- above = OR of pending bits with index > position. below = OR of pending bits with index < position. here = pending[position].
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, OFF. Outputs are Moore-decoded from the registered state.
  - MOVE_UP: motor_up=1. MOVE_DOWN: motor_down=1. DOOR_OPEN: door=1. All other states: all three 0.
  - motor_up, motor_down and door are mutually exclusive in every cycle.
- IDLE:
  - off_btn goes to OFF.
  - Else valid_floor && here goes to DOOR_OPEN.
  - Else if above or below, choose a direction. If both are set, keep dir_up. Otherwise go toward the set side. Update dir_up accordingly.
  - Else stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - Stop when valid_floor && here: go to DOOR_OPEN.
  - If off_btn && valid_floor: go to IDLE.
  - Limit stop: position==FLOORS-1 in MOVE_UP, or position==0 in MOVE_DOWN, with valid_floor goes to IDLE.
- DOOR_OPEN:
  - On entry, clear pending[position] and load counter=DOOR_CYCLES-1. The door is high for exactly DOOR_CYCLES cycles unless reloaded.
  - Counter decrements each cycle. At 0, leave DOOR_OPEN.
  - If off_btn is set on exit, go to OFF.
  - Else continue in dir_up if requests exist that way.
  - Else reverse (toggle dir_up) if requests exist the other way.
  - Else go to IDLE.
- OFF:
  - pending is cleared and all presses are ignored.
  - Motors, door, heater and cooler are all 0.
  - off_btn==0 goes to IDLE.
- Climate (registered, 1-cycle latency, independent of FSM except OFF):
  - heater sets when temp < T_LOW and clears when temp >= T_LOW+HYST.
  - cooler sets when temp > T_HIGH and clears when temp <= T_HIGH-HYST.
  - All comparisons are signed.
  - Both are forced 0 in OFF and on reset.
  - heater and cooler are never both 1.
- Simultaneous events:
  - A press and a clear of the same floor in the same edge resolve to clear, with a counter reload if the door is open there.
  - Reset dominates all other inputs.
  - Reset mid-move stops the motor on the next edge.

Test Plan:
- Reset hold, then release with position=0, at_floor=1, no presses -> all outputs 0, state IDLE, pending=0, dir_up=1.
- cabin_press_event=8'b0010_0000 pulse at floor 0 -> pending[5]=1 next cycle; motor_up=1; the bench steps position 1..5 with at_floor pulses; stop at 5; door=1 for exactly 16 cycles; pending=0; then IDLE.
- SCAN order: at floor 3 moving up, with pending floors 1, 5 and 7 -> stops at 5, then 7, then reverses (dir_up=0) to 1; motor_up and motor_down are never simultaneously high.
- Door reload: door open at floor 2; floor_press_event[2] at counter=3 -> door stays open for a further 16 cycles; pending[2] stays 0.
- off_btn=1 while moving toward floor 6 -> stops at the next valid floor, enters OFF with pending cleared and all outputs 0; presses are ignored; off_btn=0 -> IDLE.
- temp sweeps 30 -> 25 -> 20 -> 17 -> 19 (T_LOW=18, T_HIGH=26, HYST=1) -> cooler 1 then 0 (at 25); heater 0, then 1 (at 17), then 0 (at 19); each change lands 1 cycle after the temp change.
